pss_peak_detector: RTL and testbench

PSS_PEAK_DETECTOR -- requirements
Module: PSS_peak_detector

---
 rtl/pss_peak_detector.sv | 162 ++++++++++++++++
 tb/tb_pss_peak_detector.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pss_peak_detector.sv
// PSS correlation peak detector: moving-average threshold, windowed peak
// tracking and post-detection holdoff over a stream of unsigned magnitudes.
//
// Ports:
//   clk_i            - single clock, all logic on its rising edge
//   reset_ni         - asynchronous active-low reset
//   s_axis_in_tdata  - unsigned correlator magnitude (IN_DW bits)
//   s_axis_in_tvalid - sample valid, no backpressure
//   peak_valid_o     - one-cycle detection pulse
//   peak_index_o     - sample index of the detected peak (held)
//   peak_value_o     - magnitude of the detected peak (held)
module pss_peak_detector #(
    parameter int unsigned IN_DW            = 32,
    parameter int unsigned WINDOW_LEN       = 8,
    parameter int unsigned DETECTION_FACTOR = 4,
    parameter int unsigned MIN_LEVEL        = 100,
    parameter int unsigned PEAK_WIN         = 4,
    parameter int unsigned HOLDOFF_LEN      = 16,
    parameter int unsigned CNT_DW           = 16
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [IN_DW-1:0]  s_axis_in_tdata,
    input  logic              s_axis_in_tvalid,
    output logic              peak_valid_o,
    output logic [CNT_DW-1:0] peak_index_o,
    output logic [IN_DW-1:0]  peak_value_o
);

    localparam int unsigned LW    = $clog2(WINDOW_LEN);
    localparam int unsigned SUM_W = IN_DW + LW;
    localparam int unsigned FW    = $clog2(DETECTION_FACTOR + 1);
    localparam int unsigned TH_W  = IN_DW + FW;
    localparam int unsigned CM0   = (WINDOW_LEN > PEAK_WIN) ? WINDOW_LEN : PEAK_WIN;
    localparam int unsigned CMAX  = (CM0 > HOLDOFF_LEN) ? CM0 : HOLDOFF_LEN;
    localparam int unsigned CW    = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        FILL,
        SEARCH,
        TRACK,
        HOLDOFF
    } state_t;

    state_t              state_q, state_d;
    logic [IN_DW-1:0]    win_q [WINDOW_LEN];
    logic [LW-1:0]       wr_ptr_q;
    logic [SUM_W-1:0]    sum_q;
    logic [CNT_DW-1:0]   idx_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IN_DW-1:0]    max_q, max_d;
    logic [CNT_DW-1:0]   max_idx_q, max_idx_d;
    logic                report;

    logic [IN_DW-1:0]    avg;
    logic [TH_W-1:0]     threshold;
    logic                trigger;

    // Average covers only the samples preceding the current one; the
    // current sample is written into the window on the same edge.
    assign avg       = IN_DW'(sum_q >> LW);
    assign threshold = TH_W'(avg) * TH_W'(DETECTION_FACTOR);
    assign trigger   = (TH_W'(s_axis_in_tdata) > threshold) &&
                       (s_axis_in_tdata > IN_DW'(MIN_LEVEL));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        max_d     = max_q;
        max_idx_d = max_idx_q;
        report    = 1'b0;
        if (s_axis_in_tvalid) begin
            unique case (state_q)
                FILL: begin
                    if (cnt_q == CW'(WINDOW_LEN - 1)) begin
                        state_d = SEARCH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                SEARCH: begin
                    if (trigger) begin
                        max_d     = s_axis_in_tdata;
                        max_idx_d = idx_q;
                        if (PEAK_WIN <= 1) begin
                            report  = 1'b1;
                            cnt_d   = '0;
                            state_d = (HOLDOFF_LEN == 0) ? SEARCH : HOLDOFF;
                        end else begin
                            cnt_d   = CW'(1);
                            state_d = TRACK;
                        end
                    end
                end
                TRACK: begin
                    // Strict compare: ties keep the earliest sample.
                    if (s_axis_in_tdata > max_q) begin
                        max_d     = s_axis_in_tdata;
                        max_idx_d = idx_q;
                    end
                    if (cnt_q == CW'(PEAK_WIN - 1)) begin
                        report  = 1'b1;
                        cnt_d   = '0;
                        state_d = (HOLDOFF_LEN == 0) ? SEARCH : HOLDOFF;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                HOLDOFF: begin
                    if (cnt_q == CW'(HOLDOFF_LEN - 1)) begin
                        state_d = SEARCH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= FILL;
            cnt_q        <= '0;
            max_q        <= '0;
            max_idx_q    <= '0;
            idx_q        <= '0;
            sum_q        <= '0;
            wr_ptr_q     <= '0;
            peak_valid_o <= 1'b0;
            peak_index_o <= '0;
            peak_value_o <= '0;
            for (int i = 0; i < int'(WINDOW_LEN); i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            max_q        <= max_d;
            max_idx_q    <= max_idx_d;
            peak_valid_o <= report;
            if (report) begin
                peak_index_o <= max_idx_d;
                peak_value_o <= max_d;
            end
            if (s_axis_in_tvalid) begin
                // Slot at wr_ptr_q holds the oldest sample.
                sum_q <= sum_q + SUM_W'(s_axis_in_tdata)
                               - SUM_W'(win_q[wr_ptr_q]);
                win_q[wr_ptr_q] <= s_axis_in_tdata;
                wr_ptr_q        <= wr_ptr_q + LW'(1);
                idx_q           <= idx_q + CNT_DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pss_peak_detector.sv
// Directed bench for pss_peak_detector: table of baseline+spike streams
// with expected pulse data, plus hand-written reset sequences.
module tb_pss_peak_detector;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic [31:0] s_axis_in_tdata = '0;
    logic        s_axis_in_tvalid = 1'b0;
    logic        peak_valid_o;
    logic [15:0] peak_index_o;
    logic [31:0] peak_value_o;

    always #5 clk_i = ~clk_i;

    pss_peak_detector dut (
        .clk_i            (clk_i),
        .reset_ni         (reset_ni),
        .s_axis_in_tdata  (s_axis_in_tdata),
        .s_axis_in_tvalid (s_axis_in_tvalid),
        .peak_valid_o     (peak_valid_o),
        .peak_index_o     (peak_index_o),
        .peak_value_o     (peak_value_o)
    );

    typedef struct {
        string           name;
        int              n;
        int              gap;
        int              base;
        bit [5:0][31:0]  si;
        bit [5:0][31:0]  sv;
        int              exp_np;
        int              exp_at;
        int              exp_idx;
        int              exp_val;
    } vec_t;

    vec_t vt[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   np, hi, last_at;

    function automatic vec_t mk(string nm, int n, int gap, int base,
                                int enp, int at, int idx, int val);
        vec_t v;
        v.name = nm; v.n = n; v.gap = gap; v.base = base;
        v.si = '1; v.sv = '0;
        v.exp_np = enp; v.exp_at = at; v.exp_idx = idx; v.exp_val = val;
        return v;
    endfunction

    function automatic vec_t add(vec_t v, int i, int val);
        for (int k = 0; k < 6; k++) begin
            if (v.si[k] == 32'hFFFF_FFFF) begin
                v.si[k] = 32'(i);
                v.sv[k] = 32'(val);
                break;
            end
        end
        return v;
    endfunction

    function automatic int sample(vec_t v, int s);
        int r = v.base;
        for (int k = 0; k < 6; k++)
            if (v.si[k] == 32'(s)) r = int'(v.sv[k]);
        return r;
    endfunction

    task automatic chk(string nm, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        s_axis_in_tvalid = 1'b0;
        s_axis_in_tdata  = '0;
        reset_ni = 1'b0;
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
    endtask

    task automatic feed(vec_t v, int from, int to);
        for (int s = from; s < to; s++) begin
            s_axis_in_tdata  = 32'(sample(v, s));
            s_axis_in_tvalid = 1'b1;
            @(posedge clk_i);
            #1;
            s_axis_in_tvalid = 1'b0;
            if (peak_valid_o) begin
                np++; hi++; last_at = s;
            end
            for (int g = 0; g < v.gap; g++) begin
                @(posedge clk_i);
                #1;
                if (peak_valid_o) hi++;
            end
        end
    endtask

    task automatic check_run(vec_t v);
        chk({v.name, "/pulses"}, np, v.exp_np);
        chk({v.name, "/at"}, last_at, v.exp_at);
        chk({v.name, "/index"}, peak_index_o, v.exp_idx);
        chk({v.name, "/value"}, peak_value_o, v.exp_val);
        chk({v.name, "/width"}, hi, v.exp_np);
    endtask

    task automatic run(vec_t v);
        do_reset();
        chk({v.name, "/rst_valid"}, peak_valid_o, 0);
        np = 0; hi = 0; last_at = -1;
        feed(v, 0, v.n);
        @(posedge clk_i);
        #1;
        if (peak_valid_o) hi++;
        check_run(v);
    endtask

    initial begin
        vt.push_back(mk("const", 200, 0, 1000, 0, -1, 0, 0));
        vt.push_back(add(add(add(mk("req032", 40, 0, 1000, 1, 23, 21, 9000),
                     20, 5000), 21, 9000), 22, 6000));
        vt.push_back(add(add(mk("req033", 40, 0, 1000, 1, 23, 20, 9000),
                     20, 9000), 21, 9000));
        vt.push_back(add(add(add(add(add(
                     mk("req034", 60, 0, 1000, 2, 53, 50, 9000),
                     20, 5000), 21, 9000), 22, 6000), 30, 9000), 50, 9000));
        vt.push_back(add(mk("fill_spike", 40, 0, 1000, 0, -1, 0, 0),
                     3, 50000));
        vt.push_back(add(add(add(mk("gap5", 40, 5, 1000, 1, 23, 21, 9000),
                     20, 5000), 21, 9000), 22, 6000));
        vt.push_back(add(mk("below_floor", 30, 0, 10, 0, -1, 0, 0), 20, 90));
        vt.push_back(add(mk("floor_edge", 30, 0, 10, 1, 23, 20, 101),
                     20, 101));
        vt.push_back(add(mk("thr_equal", 30, 0, 1000, 0, -1, 0, 0),
                     20, 4000));
        vt.push_back(add(mk("thr_plus1", 30, 0, 1000, 1, 23, 20, 4001),
                     20, 4001));
        vt.push_back(add(add(add(mk("tie", 30, 0, 1000, 1, 23, 21, 9000),
                     20, 5000), 21, 9000), 23, 9000));
        vt.push_back(add(add(add(mk("last_in", 30, 0, 1000, 1, 23, 23, 9500),
                     20, 5000), 21, 9000), 23, 9500));
        vt.push_back(add(add(add(add(
                     mk("holdoff_end", 50, 0, 1000, 2, 43, 40, 9000),
                     20, 5000), 21, 9000), 22, 6000), 40, 9000));
        vt.push_back(add(add(add(add(
                     mk("holdoff_last", 50, 0, 1000, 1, 23, 21, 9000),
                     20, 5000), 21, 9000), 22, 6000), 39, 9000));
        vt.push_back(add(add(mk("wrap", 65545, 0, 1000, 1, 65537, 0, 9000),
                     65534, 5000), 65536, 9000));

        foreach (vt[i]) run(vt[i]);

        // Asynchronous clear of held outputs, mid-cycle.
        run(vt[1]);
        #2;
        reset_ni = 1'b0;
        #1;
        chk("async_rst/valid", peak_valid_o, 0);
        chk("async_rst/index", peak_index_o, 0);
        chk("async_rst/value", peak_value_o, 0);
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;

        // Reset mid-TRACK: no pulse, restart at index 0.
        np = 0; hi = 0; last_at = -1;
        feed(vt[1], 0, 22);
        @(posedge clk_i);
        #1;
        if (peak_valid_o) hi++;
        reset_ni = 1'b0;
        #1;
        chk("abort/index", peak_index_o, 0);
        chk("abort/value", peak_value_o, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i);
            #1;
            if (peak_valid_o) hi++;
        end
        chk("abort/no_pulse", hi, 0);
        reset_ni = 1'b1;
        np = 0; hi = 0; last_at = -1;
        feed(vt[1], 0, 40);
        check_run(vt[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
